// File: rtl/chess_timer_pkg.sv
// +--------------------------------------------------------------------------+
// | chess_timer_pkg : shared types, widths and countedTime layout            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package chess_timer_pkg;

    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);

    // countedTime = {A_min, A_sec, B_min, B_sec}; the display path slices with these
    localparam int A_MIN_LSB = 18;
    localparam int A_SEC_LSB = 12;
    localparam int B_MIN_LSB = 6;
    localparam int B_SEC_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET      = 3'd1,
        ST_READY    = 3'd2,
        ST_RUN_A    = 3'd3,
        ST_RUN_B    = 3'd4,
        ST_PAUSED_A = 3'd5,
        ST_PAUSED_B = 3'd6,
        ST_FLAG     = 3'd7
    } state_t;

    typedef struct packed {
        logic [MIN_W-1:0] mins;
        logic [SEC_W-1:0] secs;
    } clock_t;

    function automatic clock_t clock_dec(input clock_t c);
        clock_t r;
        r = c;
        if (c.secs == '0) begin
            r.secs = SEC_MAX;
            r.mins = c.mins - MIN_W'(1);
        end else begin
            r.secs = c.secs - SEC_W'(1);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chess_countdown_second_tick.sv
// +--------------------------------------------------------------------------+
// | second_tick : clearable, enableable prescaler emitting a one-cycle tick  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module second_tick #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Gated by enable so a count held during pause cannot fire a tick
    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/chess_countdown.sv
// +--------------------------------------------------------------------------+
// | chess_countdown : two-player countdown FSM and time registers            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module chess_countdown
    import chess_timer_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int MAX_MIN  = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        setTime,
    input  logic [5:0]  timeIn,
    input  logic        btnA,
    input  logic        btnB,
    input  logic        pause,
    output logic [23:0] countedTime,
    output logic        activeA,
    output logic        activeB,
    output logic        flagA,
    output logic        flagB,
    output logic        paused
);

    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

    state_t state_q, state_d;
    clock_t a_q, a_d, b_q, b_d;
    clock_t a_dec, b_dec, load_v;
    logic   flag_a_d, flag_b_d;
    logic   btn_a_q, btn_b_q, pause_q;
    logic   rise_a, rise_b, rise_p;
    logic   tick, prs_clr, prs_en;

    second_tick #(.TICK_DIV(TICK_DIV)) u_second_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (prs_clr),
        .en_i   (prs_en),
        .tick_o (tick)
    );

    assign rise_a = btnA  & ~btn_a_q;
    assign rise_b = btnB  & ~btn_b_q;
    assign rise_p = pause & ~pause_q;
    assign prs_en = (state_q == ST_RUN_A) || (state_q == ST_RUN_B);
    assign a_dec  = clock_dec(a_q);
    assign b_dec  = clock_dec(b_q);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        flag_a_d    = flagA;
        flag_b_d    = flagB;
        prs_clr     = 1'b0;
        load_v.mins = (timeIn > MAX_MIN_V) ? MAX_MIN_V : timeIn;
        load_v.secs = '0;
        if (setTime) begin
            state_d  = ST_SET;
            a_d      = load_v;
            b_d      = load_v;
            flag_a_d = 1'b0;
            flag_b_d = 1'b0;
            prs_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_SET:   state_d = (a_q.mins != '0) ? ST_READY : ST_IDLE;
                ST_READY: begin
                    if (rise_b) begin
                        state_d = ST_RUN_A;
                        prs_clr = 1'b1;
                    end else if (rise_a) begin
                        state_d = ST_RUN_B;
                        prs_clr = 1'b1;
                    end
                end
                // Flag fall takes priority; otherwise a turn switch beats pause
                ST_RUN_A: begin
                    if (tick) a_d = a_dec;
                    if (tick && a_dec == '0) begin
                        state_d  = ST_FLAG;
                        flag_a_d = 1'b1;
                    end else if (rise_a) begin
                        state_d = ST_RUN_B;
                        prs_clr = 1'b1;
                    end else if (rise_p) begin
                        state_d = ST_PAUSED_A;
                    end
                end
                ST_RUN_B: begin
                    if (tick) b_d = b_dec;
                    if (tick && b_dec == '0) begin
                        state_d  = ST_FLAG;
                        flag_b_d = 1'b1;
                    end else if (rise_b) begin
                        state_d = ST_RUN_A;
                        prs_clr = 1'b1;
                    end else if (rise_p) begin
                        state_d = ST_PAUSED_B;
                    end
                end
                ST_PAUSED_A: if (rise_p) state_d = ST_RUN_A;
                ST_PAUSED_B: if (rise_p) state_d = ST_RUN_B;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            btn_a_q <= 1'b0;
            btn_b_q <= 1'b0;
            pause_q <= 1'b0;
            flagA   <= 1'b0;
            flagB   <= 1'b0;
            activeA <= 1'b0;
            activeB <= 1'b0;
            paused  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            btn_a_q <= btnA;
            btn_b_q <= btnB;
            pause_q <= pause;
            flagA   <= flag_a_d;
            flagB   <= flag_b_d;
            activeA <= (state_d == ST_RUN_A) || (state_d == ST_PAUSED_A);
            activeB <= (state_d == ST_RUN_B) || (state_d == ST_PAUSED_B);
            paused  <= (state_d == ST_PAUSED_A) || (state_d == ST_PAUSED_B);
        end
    end

    assign countedTime = {a_q.mins, a_q.secs, b_q.mins, b_q.secs};

endmodule

`default_nettype wire

// File: tb/tb_chess_countdown.sv
// +--------------------------------------------------------------------------+
// | tb_chess_countdown : vectors, directed sequences and random vs. model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_chess_countdown;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst, setTime, btnA, btnB, pause;
    logic [5:0]  timeIn;
    logic [23:0] countedTime;
    logic        activeA, activeB, flagA, flagB, paused;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    chess_countdown #(.TICK_DIV(TD), .MAX_MIN(59)) dut (
        .clk         (clk),
        .rst         (rst),
        .setTime     (setTime),
        .timeIn      (timeIn),
        .btnA        (btnA),
        .btnB        (btnB),
        .pause       (pause),
        .countedTime (countedTime),
        .activeA     (activeA),
        .activeB     (activeB),
        .flagA       (flagA),
        .flagB       (flagB),
        .paused      (paused)
    );

    // Reference model: each player's remaining time as total seconds,
    // plus the number of running cycles since the last tick or clear.
    typedef enum int {M_IDLE, M_SET, M_READY, M_RUN_A, M_RUN_B,
                      M_PAUSE_A, M_PAUSE_B, M_FLAG} mmode_t;
    mmode_t m_mode = M_IDLE;
    int     m_a = 0, m_b = 0, m_run = 0;
    bit     m_fa = 0, m_fb = 0, m_pa = 0, m_pb = 0, m_pp = 0;

    task automatic model_step();
        bit ra, rb, rp;
        int ld;
        ra = btnA && !m_pa;
        rb = btnB && !m_pb;
        rp = pause && !m_pp;
        if (rst) begin
            m_mode = M_IDLE; m_a = 0; m_b = 0; m_run = 0;
            m_fa = 0; m_fb = 0; m_pa = 0; m_pb = 0; m_pp = 0;
            return;
        end
        m_pa = btnA; m_pb = btnB; m_pp = pause;
        if (setTime) begin
            ld = (int'(timeIn) > 59) ? 59 : int'(timeIn);
            m_a = ld * 60; m_b = ld * 60;
            m_fa = 0; m_fb = 0; m_run = 0; m_mode = M_SET;
            return;
        end
        case (m_mode)
            M_SET:   m_mode = (m_a != 0) ? M_READY : M_IDLE;
            M_READY: begin
                if (rb)      begin m_mode = M_RUN_A; m_run = 0; end
                else if (ra) begin m_mode = M_RUN_B; m_run = 0; end
            end
            M_RUN_A: begin
                m_run++;
                if (m_run == TD) begin
                    m_run = 0; m_a--;
                    if (m_a == 0) begin m_mode = M_FLAG; m_fa = 1; return; end
                end
                if (ra)      begin m_mode = M_RUN_B; m_run = 0; end
                else if (rp) m_mode = M_PAUSE_A;
            end
            M_RUN_B: begin
                m_run++;
                if (m_run == TD) begin
                    m_run = 0; m_b--;
                    if (m_b == 0) begin m_mode = M_FLAG; m_fb = 1; return; end
                end
                if (rb)      begin m_mode = M_RUN_A; m_run = 0; end
                else if (rp) m_mode = M_PAUSE_B;
            end
            M_PAUSE_A: if (rp) m_mode = M_RUN_A;
            M_PAUSE_B: if (rp) m_mode = M_RUN_B;
            default: ;
        endcase
    endtask

    function automatic logic [23:0] pk(int am, int as, int bm, int bs);
        return {6'(am), 6'(as), 6'(bm), 6'(bs)};
    endfunction

    // Status vector order: {activeA, activeB, flagA, flagB, paused}
    task automatic cmp(string nm, logic [23:0] ect, logic [4:0] est);
        logic [4:0] st;
        st = {activeA, activeB, flagA, flagB, paused};
        n_tests++;
        if (countedTime !== ect || st !== est) begin
            n_fail++;
            $display("FAIL %s: got countedTime=%h status=%b, want countedTime=%h status=%b",
                     nm, countedTime, st, ect, est);
        end
    endtask

    task automatic cyc(string nm);
        logic [4:0] est;
        @(posedge clk);
        model_step();
        #1;
        est = {m_mode == M_RUN_A || m_mode == M_PAUSE_A,
               m_mode == M_RUN_B || m_mode == M_PAUSE_B,
               m_fa, m_fb,
               m_mode == M_PAUSE_A || m_mode == M_PAUSE_B};
        cmp({nm, "/model"}, pk(m_a / 60, m_a % 60, m_b / 60, m_b % 60), est);
    endtask

    typedef struct {
        bit          r, s;
        logic [5:0]  tin;
        bit          a, b, p;
        logic [23:0] ect;
        logic [4:0]  est;
        string       nm;
    } vec_t;

    vec_t vt[12];

    initial begin
        rst = 1'b1; setTime = 1'b0; timeIn = '0; btnA = 1'b0; btnB = 1'b0; pause = 1'b0;

        vt[0]  = '{1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 24'h0,           5'b0, "reset0"};
        vt[1]  = '{1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 24'h0,           5'b0, "reset1"};
        vt[2]  = '{1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 24'h0,           5'b0, "idle_btnA"};
        vt[3]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 24'h0,           5'b0, "idle_btnB"};
        vt[4]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 24'h0,           5'b0, "idle_pause"};
        vt[5]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 24'h0,           5'b0, "idle_quiet"};
        vt[6]  = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0, 1'b0, pk(5,0,5,0),     5'b0, "load5_c0"};
        vt[7]  = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0, 1'b0, pk(5,0,5,0),     5'b0, "load5_c1"};
        vt[8]  = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0, 1'b0, pk(5,0,5,0),     5'b0, "load5_c2"};
        vt[9]  = '{1'b0, 1'b0, 6'd5,  1'b0, 1'b0, 1'b0, pk(5,0,5,0),     5'b0, "load5_ready"};
        vt[10] = '{1'b0, 1'b1, 6'd63, 1'b0, 1'b0, 1'b0, pk(59,0,59,0),   5'b0, "load63_clamp"};
        vt[11] = '{1'b0, 1'b0, 6'd63, 1'b0, 1'b0, 1'b0, pk(59,0,59,0),   5'b0, "load63_ready"};

        for (int i = 0; i < 12; i++) begin
            rst = vt[i].r; setTime = vt[i].s; timeIn = vt[i].tin;
            btnA = vt[i].a; btnB = vt[i].b; pause = vt[i].p;
            cyc(vt[i].nm);
            cmp(vt[i].nm, vt[i].ect, vt[i].est);
        end
        repeat (20) cyc("ready_hold");
        cmp("ready_no_decrement", pk(59,0,59,0), 5'b0);

        // Start A from a 5:00 load; first decrement TICK_DIV cycles after entry
        setTime = 1'b1; timeIn = 6'd5; cyc("t3_load");
        setTime = 1'b0; cyc("t3_ready");
        btnB = 1'b1; cyc("t3_start");
        cmp("t3_runA", pk(5,0,5,0), 5'b10000);
        btnB = 1'b0;
        repeat (3) cyc("t3_wait");
        cmp("t3_before_tick", pk(5,0,5,0), 5'b10000);
        cyc("t3_tick1");
        cmp("t3_A_4_59", pk(4,59,5,0), 5'b10000);
        btnB = 1'b1; cyc("t3_btnB_ignored");
        btnB = 1'b0; repeat (3) cyc("t3_wait2");
        cmp("t3_A_4_58", pk(4,58,5,0), 5'b10000);

        // btnA rise coincides with the next tick
        repeat (3) cyc("t4_wait");
        btnA = 1'b1; cyc("t4_switch");
        cmp("t4_tick_and_switch", pk(4,57,5,0), 5'b01000);
        btnA = 1'b0;
        repeat (3) cyc("t4_wait2");
        cmp("t4_B_before_tick", pk(4,57,5,0), 5'b01000);
        cyc("t4_tick");
        cmp("t4_B_4_59", pk(4,57,4,59), 5'b01000);

        // Pause one cycle after a tick; prescaler keeps the cycle already counted
        pause = 1'b1; cyc("t6_pause");
        cmp("t6_paused", pk(4,57,4,59), 5'b01001);
        pause = 1'b0;
        repeat (20) cyc("t6_hold");
        cmp("t6_frozen", pk(4,57,4,59), 5'b01001);
        pause = 1'b1; cyc("t6_resume");
        pause = 1'b0;
        cmp("t6_running", pk(4,57,4,59), 5'b01000);
        repeat (2) cyc("t6_wait");
        cmp("t6_held_presc", pk(4,57,4,59), 5'b01000);
        cyc("t6_tick");
        cmp("t6_B_4_58", pk(4,57,4,58), 5'b01000);
        rst = 1'b1; cyc("t6_rst");
        cmp("t6_rst_mid_run", 24'h0, 5'b0);
        rst = 1'b0;

        // Flag fall from 1:00, then the frozen FLAG state and reload
        setTime = 1'b1; timeIn = 6'd1; cyc("t5_load");
        setTime = 1'b0; cyc("t5_ready");
        btnB = 1'b1; cyc("t5_start");
        btnB = 1'b0;
        repeat (239) cyc("t5_run");
        cmp("t5_A_0_01", pk(0,1,1,0), 5'b10000);
        cyc("t5_last");
        cmp("t5_flagA", pk(0,0,1,0), 5'b00100);
        btnA = 1'b1; cyc("t5_f_a");
        btnA = 1'b0; btnB = 1'b1; cyc("t5_f_b");
        btnB = 1'b0; pause = 1'b1; cyc("t5_f_p");
        pause = 1'b0; cyc("t5_f_q");
        cmp("t5_flag_frozen", pk(0,0,1,0), 5'b00100);
        setTime = 1'b1; timeIn = 6'd2; cyc("t5_reload");
        cmp("t5_reload", pk(2,0,2,0), 5'b0);
        setTime = 1'b0; cyc("t5_ready");

        // Both buttons rising together in READY start A
        btnA = 1'b1; btnB = 1'b1; cyc("both_rise");
        cmp("both_rise_runA", pk(2,0,2,0), 5'b10000);
        btnA = 1'b0; btnB = 1'b0;

        // Random traffic; pause never toggles in the same cycle as a button
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst     = ($urandom_range(0, 299) == 0);
            setTime = ($urandom_range(0, 49) == 0);
            if (setTime)
                timeIn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                     : 6'($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            case (r)
                0: pause = ~pause;
                1: btnA  = ~btnA;
                2: btnB  = ~btnB;
                3: begin btnA = ~btnA; btnB = ~btnB; end
                default: ;
            endcase
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
